// File: rtl/cache_pkg.sv
// -----------------------------------------------------------------------------
// cache_pkg
// Shared definitions for the 4-line x 16-word direct-mapped data cache and
// its memory-side line fill / write-back controller.
//   - word, line and address geometry
//   - controller state encoding
//   - word-address builder (pure concatenation of line address and beat)
// -----------------------------------------------------------------------------
package cache_pkg;

    localparam int WORD_W      = 16;
    localparam int LINE_WORDS  = 16;
    localparam int LINE_W      = WORD_W * LINE_WORDS;   // 256
    localparam int TAG_W       = 10;
    localparam int INDEX_W     = 2;
    localparam int LINE_ADDR_W = TAG_W + INDEX_W;       // 12: {tag, index}
    localparam int BEAT_W      = 4;                     // log2(LINE_WORDS)
    localparam int MEM_ADDR_W  = LINE_ADDR_W + BEAT_W;  // 16

    localparam logic [BEAT_W-1:0] BEAT_FIRST = 4'd0;
    localparam logic [BEAT_W-1:0] BEAT_LAST  = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } fill_state_e;

    // Word address of one beat inside a line; concatenation only, the beat
    // counter supplies the low bits so no carry can reach the line address.
    function automatic logic [MEM_ADDR_W-1:0] word_addr(
        input logic [LINE_ADDR_W-1:0] line_addr,
        input logic [BEAT_W-1:0]      beat
    );
        return {line_addr, beat};
    endfunction

endpackage

// File: rtl/line_beat_buf.sv
// -----------------------------------------------------------------------------
// line_beat_buf
// 16 x 16-bit line buffer shared by the write-back and refill paths.
//   clk, rst   : clock, synchronous active-high clear of every word
//   line_load  : load all words from line_in (victim capture)
//   line_in    : flat line, word k at [16k+15:16k]
//   word_we    : write word_in into word word_sel (refill assembly)
//   word_sel   : word index for word_we
//   word_in    : word to write
//   rd_sel     : word index for the serialising read port
//   rd_word    : word rd_sel (combinational read of registered storage)
//   line_out   : flat view of all words, word k at [16k+15:16k]
// -----------------------------------------------------------------------------
module line_beat_buf
    import cache_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                line_load,
    input  logic [LINE_W-1:0]   line_in,
    input  logic                word_we,
    input  logic [BEAT_W-1:0]   word_sel,
    input  logic [WORD_W-1:0]   word_in,
    input  logic [BEAT_W-1:0]   rd_sel,
    output logic [WORD_W-1:0]   rd_word,
    output logic [LINE_W-1:0]   line_out
);

    logic [WORD_W-1:0] words_r [LINE_WORDS];

    // Storage: whole-line load has priority over a single-word write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                words_r[k] <= {WORD_W{1'b0}};
            end
        end else if (line_load) begin
            for (int k = 0; k < LINE_WORDS; k++) begin
                words_r[k] <= line_in[k*WORD_W +: WORD_W];
            end
        end else if (word_we) begin
            words_r[word_sel] <= word_in;
        end else begin
            words_r <= words_r;
        end
    end

    assign rd_word = words_r[rd_sel];

    // Flat view of the buffer for the refill line.
    always_comb begin
        line_out = {LINE_W{1'b0}};
        for (int k = 0; k < LINE_WORDS; k++) begin
            line_out[k*WORD_W +: WORD_W] = words_r[k];
        end
    end

endmodule

// File: rtl/line_fill_ctrl.sv
// -----------------------------------------------------------------------------
// line_fill_ctrl
// Memory-side stage of the data cache: optionally writes a dirty victim line
// back as 16 word writes, then optionally refills a line with 16 word reads.
//   clk, rst        : clock, synchronous active-high reset
//   fill_req        : refill request, held until fill_valid
//   fill_line_addr  : line to refill
//   wb_req          : write-back request, held until wb_done or fill_valid
//   wb_line_addr    : victim line address
//   wb_line         : victim data, word k at [16k+15:16k]
//   busy            : controller not idle
//   fill_valid      : one-cycle pulse, fill_data holds the refilled line
//   fill_data       : last assembled refill line
//   wb_done         : one-cycle pulse, write-back-only request finished
//   mem_addr        : word address {line_addr, beat}
//   mem_rd, mem_wr  : word read / write request, never together
//   mem_wdata       : write data
//   mem_rdata       : read data, valid with mem_ack
//   mem_ack         : current word transfer completes this cycle
// All outputs are registered.
// -----------------------------------------------------------------------------
module line_fill_ctrl
    import cache_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fill_req,
    input  logic [LINE_ADDR_W-1:0] fill_line_addr,
    input  logic                   wb_req,
    input  logic [LINE_ADDR_W-1:0] wb_line_addr,
    input  logic [LINE_W-1:0]      wb_line,
    output logic                   busy,
    output logic                   fill_valid,
    output logic [LINE_W-1:0]      fill_data,
    output logic                   wb_done,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic                   mem_rd,
    output logic                   mem_wr,
    output logic [WORD_W-1:0]      mem_wdata,
    input  logic [WORD_W-1:0]      mem_rdata,
    input  logic                   mem_ack
);

    fill_state_e            state_r;
    logic [BEAT_W-1:0]      beat_r;
    logic [BEAT_W-1:0]      beat_nx_s;
    logic [LINE_ADDR_W-1:0] fill_addr_r;
    logic [LINE_ADDR_W-1:0] wb_addr_r;
    logic                   do_fill_r;
    logic                   do_wb_r;

    logic                   accept_s;
    logic                   line_load_s;
    logic                   word_we_s;
    logic [WORD_W-1:0]      buf_word_s;
    logic [LINE_W-1:0]      buf_line_s;
    logic [LINE_W-1:0]      fill_merge_s;

    // 4-bit counter, wraps 15 -> 0 on its own.
    assign beat_nx_s = beat_r + 4'd1;

    // Request sampling and buffer write strobes.
    always_comb begin
        accept_s    = 1'b0;
        line_load_s = 1'b0;
        word_we_s   = 1'b0;
        if (state_r == IDLE) begin
            accept_s    = fill_req | wb_req;
            line_load_s = wb_req;
        end else begin
            accept_s    = 1'b0;
            line_load_s = 1'b0;
        end
        if (state_r == FILL) begin
            word_we_s = mem_ack;
        end else begin
            word_we_s = 1'b0;
        end
    end

    // The last read word lands in the buffer on the same edge that raises
    // fill_valid, so the published line is the buffer with word 15 patched in.
    always_comb begin
        fill_merge_s = buf_line_s;
        fill_merge_s[LINE_W-1 -: WORD_W] = mem_rdata;
    end

    // The read port looks one beat ahead: mem_wdata is registered, so the
    // word for the next beat must be ready when the current one is acked.
    line_beat_buf u_beat_buf (
        .clk       (clk),
        .rst       (rst),
        .line_load (line_load_s),
        .line_in   (wb_line),
        .word_we   (word_we_s),
        .word_sel  (beat_r),
        .word_in   (mem_rdata),
        .rd_sel    (beat_nx_s),
        .rd_word   (buf_word_s),
        .line_out  (buf_line_s)
    );

    // Controller FSM with registered memory-side and cache-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= IDLE;
            beat_r      <= BEAT_FIRST;
            fill_addr_r <= {LINE_ADDR_W{1'b0}};
            wb_addr_r   <= {LINE_ADDR_W{1'b0}};
            do_fill_r   <= 1'b0;
            do_wb_r     <= 1'b0;
            busy        <= 1'b0;
            fill_valid  <= 1'b0;
            wb_done     <= 1'b0;
            fill_data   <= {LINE_W{1'b0}};
            mem_addr    <= {MEM_ADDR_W{1'b0}};
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_wdata   <= {WORD_W{1'b0}};
        end else begin
            fill_valid <= 1'b0;
            wb_done    <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        fill_addr_r <= fill_line_addr;
                        wb_addr_r   <= wb_line_addr;
                        do_fill_r   <= fill_req;
                        do_wb_r     <= wb_req;
                        beat_r      <= BEAT_FIRST;
                        busy        <= 1'b1;
                        if (wb_req) begin
                            // Word 0 comes straight from the port; the buffer
                            // is loaded on this same edge.
                            state_r   <= WB;
                            mem_wr    <= 1'b1;
                            mem_rd    <= 1'b0;
                            mem_addr  <= word_addr(wb_line_addr, BEAT_FIRST);
                            mem_wdata <= wb_line[WORD_W-1:0];
                        end else begin
                            state_r   <= FILL;
                            mem_wr    <= 1'b0;
                            mem_rd    <= 1'b1;
                            mem_addr  <= word_addr(fill_line_addr, BEAT_FIRST);
                            mem_wdata <= {WORD_W{1'b0}};
                        end
                    end else begin
                        busy   <= 1'b0;
                        mem_rd <= 1'b0;
                        mem_wr <= 1'b0;
                    end
                end

                WB: begin
                    if (mem_ack) begin
                        beat_r <= beat_nx_s;
                        if (beat_r == BEAT_LAST) begin
                            mem_wr    <= 1'b0;
                            mem_wdata <= {WORD_W{1'b0}};
                            if (do_fill_r) begin
                                state_r  <= FILL;
                                mem_rd   <= 1'b1;
                                mem_addr <= word_addr(fill_addr_r, BEAT_FIRST);
                            end else begin
                                state_r <= DONE;
                                mem_rd  <= 1'b0;
                                wb_done <= do_wb_r;
                            end
                        end else begin
                            mem_addr  <= word_addr(wb_addr_r, beat_nx_s);
                            mem_wdata <= buf_word_s;
                        end
                    end else begin
                        // Unacked write: address and data hold.
                        beat_r <= beat_r;
                    end
                end

                FILL: begin
                    if (mem_ack) begin
                        beat_r <= beat_nx_s;
                        if (beat_r == BEAT_LAST) begin
                            state_r    <= DONE;
                            mem_rd     <= 1'b0;
                            fill_valid <= 1'b1;
                            fill_data  <= fill_merge_s;
                        end else begin
                            mem_addr <= word_addr(fill_addr_r, beat_nx_s);
                        end
                    end else begin
                        beat_r <= beat_r;
                    end
                end

                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                end

                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    mem_rd  <= 1'b0;
                    mem_wr  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_fill_ctrl.sv
// -----------------------------------------------------------------------------
// tb_line_fill_ctrl
// Self-checking bench for line_fill_ctrl. Expected memory transfers are queued
// when a request is driven and popped by the memory responder on every ack.
// Memory read data is the word address itself: word(a) = a.
// -----------------------------------------------------------------------------
module tb_line_fill_ctrl;
    import cache_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   fill_req;
    logic [LINE_ADDR_W-1:0] fill_line_addr;
    logic                   wb_req;
    logic [LINE_ADDR_W-1:0] wb_line_addr;
    logic [LINE_W-1:0]      wb_line;
    logic                   busy;
    logic                   fill_valid;
    logic [LINE_W-1:0]      fill_data;
    logic                   wb_done;
    logic [MEM_ADDR_W-1:0]  mem_addr;
    logic                   mem_rd;
    logic                   mem_wr;
    logic [WORD_W-1:0]      mem_wdata;
    logic [WORD_W-1:0]      mem_rdata;
    logic                   mem_ack;

    typedef struct {
        bit                    wr;
        logic [MEM_ADDR_W-1:0] addr;
        logic [WORD_W-1:0]     data;
    } xfer_t;

    xfer_t             sb[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    int                cyc     = 0;
    int                wait_n  = 0;
    int                wait_cnt = 0;
    bit                inject_ack = 1'b0;
    bit                hold_valid = 1'b0;
    logic [MEM_ADDR_W-1:0] hold_addr;
    logic [WORD_W-1:0]     hold_wdata;
    logic [LINE_W-1:0]     last_line = '0;

    line_fill_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .fill_req       (fill_req),
        .fill_line_addr (fill_line_addr),
        .wb_req         (wb_req),
        .wb_line_addr   (wb_line_addr),
        .wb_line        (wb_line),
        .busy           (busy),
        .fill_valid     (fill_valid),
        .fill_data      (fill_data),
        .wb_done        (wb_done),
        .mem_addr       (mem_addr),
        .mem_rd         (mem_rd),
        .mem_wr         (mem_wr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack)
    );

    always #5 clk = ~clk;

    // Edge counter for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [LINE_W-1:0] obs,
                       input logic [LINE_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Memory model: acks after wait_n idle request cycles, checks each acked
    // transfer against the scoreboard, checks hold stability while waiting.
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            chk("rd_wr_excl", {255'd0, mem_rd & mem_wr}, '0);
            if (hold_valid) begin
                chk("hold_addr", mem_addr, hold_addr);
                if (mem_wr) chk("hold_wdata", mem_wdata, hold_wdata);
            end
            if (wait_cnt >= wait_n) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected", mem_addr, '1);
                end else begin
                    xfer_t e;
                    e = sb.pop_front();
                    chk("sb_kind", {255'd0, mem_wr}, {255'd0, e.wr});
                    chk("sb_addr", mem_addr, e.addr);
                    if (e.wr) chk("sb_wdata", mem_wdata, e.data);
                end
                mem_ack    = 1'b1;
                mem_rdata  = mem_rd ? mem_addr : 16'h0000;
                wait_cnt   = 0;
                hold_valid = 1'b0;
            end else begin
                mem_ack    = 1'b0;
                wait_cnt   = wait_cnt + 1;
                hold_valid = 1'b1;
                hold_addr  = mem_addr;
                hold_wdata = mem_wdata;
            end
        end else begin
            mem_ack    = inject_ack;
            mem_rdata  = 16'hDEAD;
            wait_cnt   = 0;
            hold_valid = 1'b0;
        end
    end

    task automatic push_txn(input bit f, input bit w, input logic [11:0] fa,
                            input logic [11:0] wa, input logic [LINE_W-1:0] wl);
        if (w) for (int k = 0; k < 16; k++)
            sb.push_back('{1'b1, {wa, 4'(k)}, wl[k*16 +: 16]});
        if (f) for (int k = 0; k < 16; k++)
            sb.push_back('{1'b0, {fa, 4'(k)}, 16'h0000});
    endtask

    // Drive one request, hold it until the completion pulse, drop it in DONE.
    // Latency counts the request cycle as cycle 1.
    task automatic run_txn(input string name, input bit f, input bit w,
                           input logic [11:0] fa, input logic [11:0] wa,
                           input logic [LINE_W-1:0] wl, input int exp_lat);
        int k0;
        bit seen;
        logic [LINE_W-1:0] exp_line;
        exp_line = last_line;
        if (f) for (int k = 0; k < 16; k++) exp_line[k*16 +: 16] = {fa, 4'(k)};
        push_txn(f, w, fa, wa, wl);
        @(posedge clk); #1;
        k0 = cyc;
        fill_req = f; wb_req = w;
        fill_line_addr = fa; wb_line_addr = wa; wb_line = wl;
        @(posedge clk); #1;
        chk({name, "_busy_rise"}, {255'd0, busy}, 256'd1);
        seen = 1'b0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (fill_valid || wb_done) seen = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            chk({name, "_timeout"}, 256'd0, 256'd1);
            fill_req = 1'b0; wb_req = 1'b0;
        end else begin
            chk({name, "_latency"}, cyc - k0 + 1, exp_lat);
            chk({name, "_fill_valid"}, {255'd0, fill_valid}, {255'd0, f});
            chk({name, "_wb_done"}, {255'd0, wb_done}, {255'd0, !f});
            chk({name, "_fill_data"}, fill_data, exp_line);
            chk({name, "_busy_done"}, {255'd0, busy}, 256'd1);
            fill_req = 1'b0; wb_req = 1'b0;
            @(posedge clk); #1;
            chk({name, "_pulse_end"}, {254'd0, fill_valid, wb_done}, 256'd0);
            chk({name, "_busy_fall"}, {255'd0, busy}, 256'd0);
            chk({name, "_sb_drained"}, sb.size(), 256'd0);
        end
        last_line = exp_line;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [LINE_W-1:0] line_b;
        logic [LINE_W-1:0] line_r;
        int pulses;
        rst = 1'b1; fill_req = 1'b0; wb_req = 1'b0;
        fill_line_addr = '0; wb_line_addr = '0; wb_line = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy",       {255'd0, busy},       '0);
        chk("rst_fill_valid", {255'd0, fill_valid}, '0);
        chk("rst_wb_done",    {255'd0, wb_done},    '0);
        chk("rst_fill_data",  fill_data,            '0);
        chk("rst_mem_addr",   mem_addr,             '0);
        chk("rst_mem_rd",     {255'd0, mem_rd},     '0);
        chk("rst_mem_wr",     {255'd0, mem_wr},     '0);
        chk("rst_mem_wdata",  mem_wdata,            '0);
        rst = 1'b0;

        run_txn("fill", 1'b1, 1'b0, 12'h0A5, 12'h000, '0, 18);

        for (int k = 0; k < 16; k++) line_b[k*16 +: 16] = 16'hB000 + 16'(k);
        run_txn("wbfill", 1'b1, 1'b1, 12'h001, 12'h3C1, line_b, 34);

        wait_n = 2;
        run_txn("wait", 1'b1, 1'b0, 12'h2D4, 12'h000, '0, 50);
        wait_n = 0;

        for (int k = 0; k < 8; k++) line_r[k*32 +: 32] = $urandom;
        run_txn("wbonly", 1'b0, 1'b1, 12'h000, 12'h7E2, line_r, 18);

        // Reset while beat 7 of a fill is on the bus.
        push_txn(1'b1, 1'b0, 12'h15E, 12'h000, '0);
        @(posedge clk); #1;
        fill_req = 1'b1; fill_line_addr = 12'h15E;
        repeat (8) @(posedge clk);
        #1;
        chk("rstmid_beat7_addr", mem_addr, 16'h15E7);
        rst = 1'b1; fill_req = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_busy",       {255'd0, busy},       '0);
        chk("rstmid_mem_rd",     {255'd0, mem_rd},     '0);
        chk("rstmid_fill_data",  fill_data,            '0);
        chk("rstmid_fill_valid", {255'd0, fill_valid}, '0);
        rst = 1'b0;
        sb.delete();
        last_line = '0;
        pulses = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (fill_valid || wb_done) pulses++;
        end
        chk("rstmid_no_pulse", pulses, '0);

        run_txn("refill", 1'b1, 1'b0, 12'hFFF, 12'h000, '0, 18);

        // Stray acks in IDLE must not start anything.
        inject_ack = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            chk("idle_ack_busy", {255'd0, busy}, '0);
            chk("idle_ack_req",  {254'd0, mem_rd, mem_wr}, '0);
        end
        inject_ack = 1'b0;
        chk("idle_ack_sb", sb.size(), '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
